// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient-path types for the pre/post-processing stages.
package kyber_pkg;
  localparam int unsigned Q             = 3329;
  localparam int unsigned NINV          = 3303;
  localparam int unsigned BARRETT_M     = 5039;
  localparam int unsigned BARRETT_SHIFT = 24;
  localparam int unsigned N_COEF        = 256;
  localparam int unsigned COEF_W        = 12;
  localparam int unsigned PROD_W        = 24;
  localparam int unsigned RED_W         = 14;
  localparam int unsigned CNT_W         = $clog2(N_COEF);

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic {
    MODE_INTT = 1'b0,
    MODE_NTT  = 1'b1
  } mode_e;

  // Payload held in the first pipeline stage.
  typedef struct packed {
    logic [PROD_W-1:0] p;
    coef_t             data;
    mode_e             mode;
    logic              last;
  } s1_beat_t;
endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of a 24-bit product into [0, Q-1], with an optional
// bypass value carried alongside so the result register can also forward raw data.
module barrett_reduce
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_s2_i,
  input  logic              en_s3_i,
  input  logic [PROD_W-1:0] p_i,
  input  logic              byp_i,
  input  coef_t             byp_val_i,
  output coef_t             r_o
);
  localparam int unsigned MUL_W = PROD_W + 13;

  logic [MUL_W-1:0]  prod_c;
  coef_t             qe_c;
  logic [PROD_W-1:0] qq_c;
  logic [RED_W-1:0]  r1_c, r2_c;
  logic [RED_W-1:0]  r_d, r_q;
  logic              byp_d, byp_q;
  coef_t             bv_d, bv_q;
  coef_t             res_d, res_q;

  always_comb begin
    r_d   = r_q;
    byp_d = byp_q;
    bv_d  = bv_q;
    res_d = res_q;
    // S2: quotient estimate; remainder is below 3Q so it fits in 14 bits.
    prod_c = MUL_W'(p_i) * MUL_W'(BARRETT_M);
    qe_c   = COEF_W'(prod_c >> BARRETT_SHIFT);
    qq_c   = PROD_W'(qe_c) * PROD_W'(Q);
    if (en_s2_i) begin
      r_d   = RED_W'(p_i - qq_c);
      byp_d = byp_i;
      bv_d  = byp_val_i;
    end
    // S3: at most two conditional subtractions.
    r1_c = (r_q >= RED_W'(Q)) ? r_q - RED_W'(Q) : r_q;
    r2_c = (r1_c >= RED_W'(Q)) ? r1_c - RED_W'(Q) : r1_c;
    if (en_s3_i) begin
      res_d = byp_q ? bv_q : COEF_W'(r2_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      byp_q <= 1'b0;
      bv_q  <= '0;
      res_q <= '0;
    end else begin
      r_q   <= r_d;
      byp_q <= byp_d;
      bv_q  <= bv_d;
      res_q <= res_d;
    end
  end

  assign r_o = res_q;
endmodule

// File: rtl/postprocess.sv
// Coefficient output stage: INTT scaling by n^-1 with full reduction, NTT pass-through,
// 3-stage valid/ready pipeline, per-polynomial beat counter and sticky framing error.
module postprocess
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              NTT_INTT_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);
  s1_beat_t         s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic             s3_valid_d, s3_valid_q;
  logic             s2_last_d, s2_last_q;
  logic             s3_last_d, s3_last_q;
  logic [CNT_W-1:0] in_cnt_d, in_cnt_q;
  mode_e            mode_d, mode_q;
  logic             frame_err_d, frame_err_q;

  logic  load1_c, load2_c, load3_c, accept_c, cnt_last_c, cnt_first_c;
  mode_e beat_mode_c;

  // A stage loads when it is empty or its successor is loading.
  assign load3_c     = !s3_valid_q || out_ready;
  assign load2_c     = !s2_valid_q || load3_c;
  assign load1_c     = !s1_valid_q || load2_c;
  assign accept_c    = in_valid && load1_c;
  assign cnt_first_c = (in_cnt_q == '0);
  assign cnt_last_c  = (in_cnt_q == CNT_W'(N_COEF - 1));
  assign beat_mode_c = cnt_first_c ? mode_e'(NTT_INTT_sel) : mode_q;

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s3_valid_d  = s3_valid_q;
    s2_last_d   = s2_last_q;
    s3_last_d   = s3_last_q;
    in_cnt_d    = in_cnt_q;
    mode_d      = mode_q;
    frame_err_d = frame_err_q;
    if (load1_c) begin
      s1_valid_d = in_valid;
      if (accept_c) begin
        s1_d.p    = PROD_W'(in_data) * PROD_W'(NINV);
        s1_d.data = in_data;
        s1_d.mode = beat_mode_c;
        s1_d.last = cnt_last_c;
      end
    end
    if (load2_c) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_q.last;
    end
    if (load3_c) begin
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
    end
    // Mode is only sampled on the first beat of a polynomial.
    if (accept_c) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
      if (cnt_first_c) begin
        mode_d = mode_e'(NTT_INTT_sel);
      end
      if (in_last != cnt_last_c) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_last_q   <= 1'b0;
      in_cnt_q    <= '0;
      mode_q      <= MODE_INTT;
      frame_err_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      s2_last_q   <= s2_last_d;
      s3_last_q   <= s3_last_d;
      in_cnt_q    <= in_cnt_d;
      mode_q      <= mode_d;
      frame_err_q <= frame_err_d;
    end
  end

  barrett_reduce u_barrett (
    .clk       (clk),
    .rst       (rst),
    .en_s2_i   (load2_c),
    .en_s3_i   (load3_c),
    .p_i       (s1_q.p),
    .byp_i     (s1_q.mode == MODE_NTT),
    .byp_val_i (s1_q.data),
    .r_o       (out_data)
  );

  assign in_ready  = load1_c;
  assign out_valid = s3_valid_q;
  assign out_last  = s3_last_q;
  assign frame_err = frame_err_q;
endmodule
